// File: rtl/config_loader.sv
// Serial bitstream loader for the BLE configuration shift chain: host words in, one bit per two clk out.
// Optional CRC-16-CCITT over the shifted bits is enabled by defining CONFIG_LOADER_CRC_EN.
module config_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int CHAIN_LENGTH = 650
) (
    input  logic                  clk,
    input  logic                  sys_reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  config_out,
    output logic                  config_clk,
    output logic                  config_en,
    output logic                  busy,
    output logic                  done
`ifdef CONFIG_LOADER_CRC_EN
    ,
    output logic [15:0]           crc_out
`endif
);

    localparam int CNT_WIDTH = $clog2(CHAIN_LENGTH + 1);
    localparam int SR_CW     = $clog2(WORD_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRIVE,
        S_STROBE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [WORD_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic [WORD_WIDTH-1:0] r_sr;
    logic [SR_CW-1:0]      r_sr_left;
    logic [CNT_WIDTH-1:0]  r_bit_cnt;

    logic                  r_s_ready;
    logic                  r_config_out;
    logic                  r_config_clk;
    logic                  r_config_en;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_handshake;
    logic                  w_reload;
    logic                  w_clear;
    logic                  w_last_bit;
    logic                  w_busy_next;
    logic                  w_hold_valid_next;
    logic [WORD_WIDTH-1:0] w_hold_next;
    logic [WORD_WIDTH-1:0] w_sr_next;
    logic [SR_CW-1:0]      w_sr_left_next;
    logic [CNT_WIDTH-1:0]  w_bit_cnt_next;

    assign w_handshake = s_valid & r_s_ready;
    assign w_last_bit  = (r_bit_cnt == CNT_WIDTH'(CHAIN_LENGTH - 1));

    // Next-state logic. w_reload moves HOLD into SR; w_clear is an accepted start.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_next_state = r_state;
        w_reload     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state = S_FETCH;
                    w_clear      = 1'b1;
                end
            end
            S_FETCH: begin
                if (r_hold_valid) begin
                    w_next_state = S_DRIVE;
                    w_reload     = 1'b1;
                end
            end
            S_DRIVE: w_next_state = S_STROBE;
            S_STROBE: begin
                if (w_last_bit) begin
                    w_next_state = S_DONE;
                end else if (r_sr_left > SR_CW'(1)) begin
                    w_next_state = S_DRIVE;
                end else if (r_hold_valid) begin
                    w_next_state = S_DRIVE;
                    w_reload     = 1'b1;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Buffer and counter updates; a reload and a handshake in one cycle hand HOLD over and refill it.
    always_comb begin
        w_sr_next         = r_sr;
        w_sr_left_next    = r_sr_left;
        w_hold_next       = r_hold;
        w_hold_valid_next = r_hold_valid;
        w_bit_cnt_next    = r_bit_cnt;

        if (w_reload) begin
            w_sr_next         = r_hold;
            w_sr_left_next    = SR_CW'(WORD_WIDTH);
            w_hold_valid_next = 1'b0;
        end else if (r_state == S_STROBE) begin
            w_sr_next      = r_sr >> 1;
            w_sr_left_next = r_sr_left - SR_CW'(1);
        end

        if (w_handshake) begin
            w_hold_next       = s_data;
            w_hold_valid_next = 1'b1;
        end

        if (r_state == S_STROBE) begin
            w_bit_cnt_next = r_bit_cnt + CNT_WIDTH'(1);
        end

        if (w_clear) begin
            w_sr_left_next    = '0;
            w_hold_valid_next = 1'b0;
            w_bit_cnt_next    = '0;
        end else if (w_next_state == S_DONE) begin
            w_hold_valid_next = 1'b0;
        end
    end

    assign w_busy_next = (w_next_state == S_FETCH) || (w_next_state == S_DRIVE) ||
                         (w_next_state == S_STROBE);

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (sys_reset) begin
            r_state      <= S_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_sr         <= '0;
            r_sr_left    <= '0;
            r_bit_cnt    <= '0;
            r_s_ready    <= 1'b0;
            r_config_out <= 1'b0;
            r_config_clk <= 1'b0;
            r_config_en  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_hold       <= w_hold_next;
            r_hold_valid <= w_hold_valid_next;
            r_sr         <= w_sr_next;
            r_sr_left    <= w_sr_left_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_s_ready    <= w_busy_next & ~w_hold_valid_next;
            r_config_out <= (w_next_state == S_DRIVE) ? w_sr_next[0] : r_config_out;
            r_config_clk <= (w_next_state == S_STROBE);
            r_config_en  <= (w_next_state == S_DRIVE) || (w_next_state == S_STROBE);
            r_busy       <= w_busy_next;
            r_done       <= (w_next_state == S_DONE);
        end
    end

    assign s_ready    = r_s_ready;
    assign config_out = r_config_out;
    assign config_clk = r_config_clk;
    assign config_en  = r_config_en;
    assign busy       = r_busy;
    assign done       = r_done;

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] r_crc;
    logic        w_crc_fb;

    // CRC-16-CCITT, MSB-first, fed with the bit presented on config_out during each strobe.
    assign w_crc_fb = r_crc[15] ^ r_config_out;

    always_ff @(posedge clk) begin
        if (sys_reset || w_clear) begin
            r_crc <= 16'hFFFF;
        end else if (r_state == S_STROBE) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign crc_out = r_crc;
`else
    // Default build carries no CRC state.
`endif

endmodule
